// File: rtl/systolic_seq_ctrl_if.sv
// Command/status bundle between the host-side issuer and the systolic sequencer.
// The master modport issues commands and sees status; the slave modport is the sequencer.
interface systolic_seq_ctrl_if #(
  parameter int K_W     = 8,
  parameter int T_W     = 8,
  parameter int CYCLE_W = 10
);
  logic               start_i;
  logic [K_W-1:0]     k_len_i;
  logic [T_W-1:0]     n_tiles_i;
  logic               stall_i;
  logic               abort_i;
  logic [2:0]         state_o;
  logic               busy_o;
  logic               done_o;
  logic               aborted_o;
  logic [CYCLE_W-1:0] phase_cnt_o;
  logic [T_W-1:0]     tile_idx_o;
  logic               load_en_o;
  logic               mac_en_o;
  logic               store_en_o;

  modport master (
    output start_i, k_len_i, n_tiles_i, stall_i, abort_i,
    input  state_o, busy_o, done_o, aborted_o, phase_cnt_o, tile_idx_o,
           load_en_o, mac_en_o, store_en_o
  );

  modport slave (
    input  start_i, k_len_i, n_tiles_i, stall_i, abort_i,
    output state_o, busy_o, done_o, aborted_o, phase_cnt_o, tile_idx_o,
           load_en_o, mac_en_o, store_en_o
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer LOAD_X -> MAC -> STORE per tile, then DONE; state is registered, enables are combinational.
// A stall freezes the phase counter and drops the enables that cycle; abort overrides stall and every transition.
module systolic_seq_ctrl #(
  parameter int ROWS    = 2,
  parameter int COLS    = 4,
  parameter int K_W     = 8,
  parameter int T_W     = 8,
  parameter int CYCLE_W = 10
) (
  input logic               clk,
  input logic               rst_n,
  systolic_seq_ctrl_if.slave io
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Last phase_cnt value per phase; MAC covers skew fill, accumulation and drain.
  localparam logic [CYCLE_W-1:0] IO_LAST   = CYCLE_W'(ROWS - 1);
  localparam logic [CYCLE_W-1:0] MAC_EXTRA = CYCLE_W'(ROWS + COLS - 3);

  logic [2:0]         state_q, state_d;
  logic [CYCLE_W-1:0] phase_q, phase_d;
  logic [T_W-1:0]     tile_q, tile_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [T_W-1:0]     n_q, n_d;
  logic               aborted_q, aborted_d;
  logic [CYCLE_W-1:0] phase_last;

  always_comb begin
    phase_last = IO_LAST;
    if (state_q == S_MAC) phase_last = CYCLE_W'(k_q) + MAC_EXTRA;
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tile_d    = tile_q;
    k_d       = k_q;
    n_d       = n_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        tile_d  = '0;
        if (io.start_i && !io.abort_i) begin
          state_d = S_LOAD;
          k_d     = (io.k_len_i == '0) ? K_W'(1) : io.k_len_i;
          n_d     = (io.n_tiles_i == '0) ? T_W'(1) : io.n_tiles_i;
        end
      end
      S_LOAD, S_MAC, S_STORE: begin
        if (io.abort_i) begin
          state_d   = S_IDLE;
          phase_d   = '0;
          tile_d    = '0;
          aborted_d = 1'b1;
        end else if (!io.stall_i) begin
          if (phase_q == phase_last) begin
            phase_d = '0;
            if (state_q == S_LOAD) begin
              state_d = S_MAC;
            end else if (state_q == S_MAC) begin
              state_d = S_STORE;
            end else if (tile_q == n_q - T_W'(1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
              tile_d  = tile_q + T_W'(1);
            end
          end else begin
            phase_d = phase_q + CYCLE_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        phase_d   = '0;
        tile_d    = '0;
        aborted_d = io.abort_i;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        tile_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      tile_q    <= '0;
      k_q       <= K_W'(1);
      n_q       <= T_W'(1);
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tile_q    <= tile_d;
      k_q       <= k_d;
      n_q       <= n_d;
      aborted_q <= aborted_d;
    end
  end

  assign io.state_o     = state_q;
  assign io.busy_o      = (state_q != S_IDLE);
  assign io.done_o      = (state_q == S_DONE);
  assign io.aborted_o   = aborted_q;
  assign io.phase_cnt_o = phase_q;
  assign io.tile_idx_o  = tile_q;
  assign io.load_en_o   = (state_q == S_LOAD)  && !io.stall_i;
  assign io.mac_en_o    = (state_q == S_MAC)   && !io.stall_i;
  assign io.store_en_o  = (state_q == S_STORE) && !io.stall_i;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed scenarios plus random traffic against a schedule-queue model.
// The model expands each accepted command into its full list of (state, phase, tile) cycles.
module tb_systolic_seq_ctrl;
  localparam int ROWS = 2;
  localparam int COLS = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] ph;
    logic [7:0] ti;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.K_W(8), .T_W(8), .CYCLE_W(10)) bus ();

  systolic_seq_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .K_W(8), .T_W(8), .CYCLE_W(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus)
  );

  ent_t q[$];
  logic ab_exp = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no, n_load, n_mac, n_store, n_done, done_at, n_busy_nd, n_abp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expand a command into the exact cycle schedule it should follow when never stalled.
  function automatic void build(input int k, input int n);
    int ke = (k == 0) ? 1 : k;
    int ne = (n == 0) ? 1 : n;
    for (int t = 0; t < ne; t++) begin
      for (int p = 0; p < ROWS; p++) q.push_back('{3'd1, 10'(p), 8'(t)});
      for (int p = 0; p < ke + ROWS + COLS - 2; p++) q.push_back('{3'd2, 10'(p), 8'(t)});
      for (int p = 0; p < ROWS; p++) q.push_back('{3'd3, 10'(p), 8'(t)});
    end
    q.push_back('{3'd4, 10'd0, 8'(ne - 1)});
  endfunction

  function automatic void model_edge(input logic st, input logic stl, input logic ab,
                                     input logic [7:0] k, input logic [7:0] n);
    ab_exp = 1'b0;
    if (q.size() == 0) begin
      if (st && !ab) build(int'(k), int'(n));
    end else if (ab) begin
      q.delete();
      ab_exp = 1'b1;
    end else if (q[0].st == 3'd4 || !stl) begin
      void'(q.pop_front());
    end
  endfunction

  task automatic compare_all();
    ent_t h;
    logic s;
    h = (q.size() != 0) ? q[0] : '{3'd0, 10'd0, 8'd0};
    s = bus.stall_i;
    check("state", 32'(bus.state_o), 32'(h.st));
    check("busy", 32'(bus.busy_o), 32'(q.size() != 0));
    check("done", 32'(bus.done_o), 32'(h.st == 3'd4));
    check("aborted", 32'(bus.aborted_o), 32'(ab_exp));
    check("phase_cnt", 32'(bus.phase_cnt_o), 32'(h.ph));
    check("tile_idx", 32'(bus.tile_idx_o), 32'(h.ti));
    check("load_en", 32'(bus.load_en_o), 32'(h.st == 3'd1 && !s));
    check("mac_en", 32'(bus.mac_en_o), 32'(h.st == 3'd2 && !s));
    check("store_en", 32'(bus.store_en_o), 32'(h.st == 3'd3 && !s));
  endtask

  task automatic clear_stats();
    step_no = 0; n_load = 0; n_mac = 0; n_store = 0;
    n_done = 0; done_at = 0; n_busy_nd = 0; n_abp = 0;
  endtask

  task automatic step(input logic st, input logic stl, input logic ab,
                      input logic [7:0] k, input logic [7:0] n);
    bus.start_i = st; bus.stall_i = stl; bus.abort_i = ab;
    bus.k_len_i = k;  bus.n_tiles_i = n;
    #1;
    compare_all();
    step_no++;
    if (bus.load_en_o) n_load++;
    if (bus.mac_en_o) n_mac++;
    if (bus.store_en_o) n_store++;
    if (bus.done_o) begin n_done++; done_at = step_no; end
    if (bus.busy_o && !bus.done_o) n_busy_nd++;
    if (bus.aborted_o) n_abp++;
    @(posedge clk);
    model_edge(st, stl, ab, k, n);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    int stalls;
    bit hit;
    bus.start_i = 1'b0; bus.stall_i = 1'b0; bus.abort_i = 1'b0;
    bus.k_len_i = 8'd0; bus.n_tiles_i = 8'd0;
    clear_stats();

    // Reset state
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single tile, k=3
    clear_stats();
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
    idle(14);
    check("t1_load_cnt", 32'(n_load), 32'd2);
    check("t1_mac_cnt", 32'(n_mac), 32'd7);
    check("t1_store_cnt", 32'(n_store), 32'd2);
    check("t1_done_at", 32'(done_at), 32'd13);
    check("t1_done_cnt", 32'(n_done), 32'd1);

    // Three tiles back to back
    clear_stats();
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd3);
    idle(38);
    check("t2_busy_cycles", 32'(n_busy_nd), 32'd33);
    check("t2_mac_cnt", 32'(n_mac), 32'd21);
    check("t2_done_cnt", 32'(n_done), 32'd1);

    // Three stall cycles at MAC phase 4
    clear_stats();
    stalls = 0;
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
    for (int i = 0; i < 18; i++) begin
      hit = (q.size() != 0) && q[0].st == 3'd2 && q[0].ph == 10'd4 && stalls < 3;
      if (hit) stalls++;
      step(1'b0, hit, 1'b0, 8'd0, 8'd0);
    end
    check("t3_stalls_applied", 32'(stalls), 32'd3);
    check("t3_done_at", 32'(done_at), 32'd16);
    check("t3_mac_cnt", 32'(n_mac), 32'd7);

    // Abort during MAC of tile 1, then immediate restart
    clear_stats();
    hit = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd3);
    for (int i = 0; i < 40 && !hit; i++) begin
      hit = (q.size() != 0) && q[0].st == 3'd2 && q[0].ti == 8'd1 && q[0].ph == 10'd2;
      step(1'b0, 1'b0, hit, 8'd0, 8'd0);
    end
    check("t4_abort_reached", 32'(hit), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
    check("t4_aborted_pulse", 32'(n_abp), 32'd1);
    check("t4_no_done", 32'(n_done), 32'd0);
    idle(14);
    check("t4_restart_done", 32'(n_done), 32'd1);
    check("t4_single_pulse", 32'(n_abp), 32'd1);

    // Zero k/n, restart while busy, start+abort in idle
    clear_stats();
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd9, 8'd9);
    idle(10);
    check("t5_mac_cnt", 32'(n_mac), 32'd5);
    check("t5_done_at", 32'(done_at), 32'd11);
    check("t5_done_cnt", 32'(n_done), 32'd1);
    step(1'b1, 1'b0, 1'b1, 8'd3, 8'd1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check("t5_start_abort_busy", 32'(bus.busy_o), 32'd0);

    // Asynchronous reset during STORE
    hit = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      hit = (q.size() != 0) && q[0].st == 3'd3;
    end
    check("t6_store_reached", 32'(hit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    ab_exp = 1'b0;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    clear_stats();
    step(1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
    idle(13);
    check("t6_resume_done_at", 32'(done_at), 32'd13);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0),
           8'($urandom_range(0, 6)), 8'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Parametrised sequencer for the systolic MAC array. It replaces the fixed single-pass controller with one that takes a runtime accumulation depth and tile count, honours downstream back-pressure (stall), supports abort, and signals completion through a start/busy/done handshake. It sits between the host command interface and the array/IO-buffer enables, and drives per-phase enables and counters for the PE grid and the load/store datapaths.

## Interface
- ROWS, 2, array row count (≥1)
- COLS, 4, array column count (≥1)
- K_W, 8, width of accumulation-depth input
- T_W, 8, width of tile-count input
- CYCLE_W, 10, phase counter width; must hold (2^K_W−1)+ROWS+COLS−2

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  command request; sampled only in IDLE
- k_len  in  K_W  accumulation depth per tile; latched on accepted start; 0 treated as 1
- n_tiles  in  T_W  tiles per command; latched on accepted start; 0 treated as 1
- stall  in  1  back-pressure; freezes LOAD_X/MAC/STORE
- abort  in  1  cancel current command
- state  out  3  0 IDLE, 1 LOAD_X, 2 MAC, 3 STORE, 4 DONE
- busy  out  1  state ≠ IDLE
- done  out  1  high exactly in DONE (one cycle)
- aborted  out  1  one-cycle pulse after an accepted abort
- phase_cnt  out  CYCLE_W  cycles completed in current phase (0-based)
- tile_idx  out  T_W  current tile, 0-based
- load_en / mac_en / store_en  out  1 each  state==LOAD_X/MAC/STORE and !stall (combinational)

## Operation
- Phase lengths: LOAD_X = ROWS cycles; MAC = k_len+ROWS+COLS−2 cycles (skew fill + accumulate + drain); STORE = ROWS cycles.
- IDLE: start=1 and abort=0 → LOAD_X, phase_cnt=0, tile_idx=0, k/n latched. Otherwise hold.
- LOAD_X/MAC/STORE: if stall, hold state and phase_cnt. Else on phase_cnt == len−1 advance to next phase with phase_cnt=0; else phase_cnt+1.
- End of STORE: tile_idx < n_tiles−1 → tile_idx+1, LOAD_X; else DONE.
- DONE: unconditionally → IDLE next cycle; tile_idx and phase_cnt cleared to 0 on entry to IDLE.
- abort=1 in LOAD_X/MAC/STORE/DONE: next cycle IDLE, counters 0, aborted=1 for one cycle, done never asserted for that command. abort beats stall and any phase transition. abort in IDLE ignored and blocks start that cycle.
- start while busy ignored (not queued). k_len/n_tiles changes after acceptance have no effect.
- Illegal state encodings (5–7) → IDLE, counters 0.

## Timing
- Reset: state=IDLE, busy=0, done=0, aborted=0, phase_cnt=0, tile_idx=0, all enables 0.
- Start accepted at edge E0: LOAD_X visible from E0. Unstalled single tile, total latency start→done = ROWS + MAC + ROWS cycles; done visible for exactly the cycle after the last STORE cycle, busy drops one cycle after that.
- Each stalled cycle adds exactly one cycle of latency; enables deassert in the same cycle stall is high.
- Tiles are back-to-back: STORE last cycle → LOAD_X of next tile with no idle gap.

## Test plan
- ROWS=2, COLS=4, k_len=3, n_tiles=1, start at E0 → LOAD_X 2 cycles, MAC 7, STORE 2, done high after E11 for one cycle, IDLE after E12; load_en/mac_en/store_en counts 2/7/2.
- Same with n_tiles=3 → tile_idx steps 0,1,2 with no gaps; done once after 33 busy cycles; mac_en total 21.
- Same as first with stall high for 3 cycles mid-MAC (phase_cnt=4) → phase_cnt holds at 4, mac_en low those cycles, done delayed exactly 3 cycles.
- abort during MAC of tile 1 (n_tiles=3) → next cycle IDLE, aborted one pulse, done never asserted, tile_idx=0; new start accepted the following cycle.
- k_len=0, n_tiles=0 → treated as 1/1: MAC = ROWS+COLS−1 cycles, one tile; start pulsed again while busy and start with abort in IDLE → both ignored.
- Assert rst_n low mid-STORE → all outputs at reset values asynchronously; resumes normally after release.
